// File: rtl/cw305_ascon_stream_bank.sv
// CW305 host register bank and word streamer for an Ascon core, single crypto clock domain.
// The host fills DIN byte-wise, issues start/init, the block streams LEN words and collects results into DOUT.
module cw305_ascon_stream_bank #(
    parameter int pADDR_WIDTH   = 8,
    parameter int pBYTECNT_SIZE = 8,
    parameter int pWORD_WIDTH   = 32,
    parameter int pNUM_WORDS    = 64,
    parameter int pCNT_WIDTH    = 32
) (
    input  logic                     crypto_clk,
    input  logic                     reset_n,
    input  logic [pADDR_WIDTH-1:0]   reg_address,
    input  logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
    input  logic [7:0]               write_data,
    input  logic                     reg_write,
    input  logic                     reg_read,
    input  logic                     reg_addrvalid,
    output logic [7:0]               read_data,
    output logic [pWORD_WIDTH-1:0]   O_word,
    output logic                     O_word_valid,
    output logic                     O_word_last,
    input  logic                     I_word_ready,
    input  logic [pWORD_WIDTH-1:0]   I_out_word,
    input  logic                     I_out_valid,
    output logic                     O_out_ready,
    output logic                     O_start,
    output logic                     O_init,
    input  logic                     I_done,
    output logic                     O_busy
);

    localparam int unsigned BPW   = pWORD_WIDTH / 8;
    localparam int unsigned NB    = pNUM_WORDS * BPW;
    localparam int unsigned NB_W  = $clog2(NB);
    localparam int unsigned IDX_W = $clog2(pNUM_WORDS);
    localparam int unsigned PTR_W = IDX_W + 1;
    localparam int unsigned CBW   = ((pCNT_WIDTH + 7) / 8) * 8;

    localparam logic [pADDR_WIDTH-1:0] A_CTRL   = pADDR_WIDTH'(8'h00);
    localparam logic [pADDR_WIDTH-1:0] A_STATUS = pADDR_WIDTH'(8'h01);
    localparam logic [pADDR_WIDTH-1:0] A_LEN    = pADDR_WIDTH'(8'h02);
    localparam logic [pADDR_WIDTH-1:0] A_OUTCNT = pADDR_WIDTH'(8'h03);
    localparam logic [pADDR_WIDTH-1:0] A_CYCLES = pADDR_WIDTH'(8'h04);
    localparam logic [pADDR_WIDTH-1:0] A_DIN    = pADDR_WIDTH'(8'h10);
    localparam logic [pADDR_WIDTH-1:0] A_DOUT   = pADDR_WIDTH'(8'h11);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;

    localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(pNUM_WORDS);

    logic [1:0]            r_state;
    logic [7:0]            r_len;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [pCNT_WIDTH-1:0] r_cycles;
    logic                  r_done;
    logic                  r_ovf;
    logic                  r_unf;
    logic                  r_ign;
    logic                  r_done_q;
    logic                  r_start;
    logic                  r_init;
    logic [7:0]            r_read;
    logic [7:0]            r_din  [NB];
    logic [7:0]            r_dout [NB];

    logic                   w_busy;
    logic                   w_stream;
    logic [PTR_W-1:0]       w_len_eff;
    logic                   w_last;
    logic                   w_hs;
    logic                   w_done_rise;
    logic                   w_wr_en;
    logic                   w_rd_en;
    logic                   w_ctrl_wr;
    logic                   w_accept;
    logic [NB_W-1:0]        w_bidx;
    logic                   w_bidx_ok;
    logic                   w_din_wr;
    logic                   w_res_store;
    logic [pWORD_WIDTH-1:0] w_word;
    logic [CBW-1:0]         w_cyc_ext;
    logic [7:0]             w_rd_byte;

    assign w_busy      = (r_state != S_IDLE);
    assign w_stream    = (r_state == S_STREAM);
    assign w_len_eff   = (32'(r_len) >= pNUM_WORDS) ? PTR_FULL : PTR_W'(r_len);
    assign w_last      = w_stream && (r_rd_ptr == w_len_eff - PTR_W'(1));
    assign w_hs        = w_stream && I_word_ready;
    assign w_done_rise = I_done && !r_done_q;
    assign w_wr_en     = reg_write && reg_addrvalid;
    assign w_rd_en     = reg_read && reg_addrvalid;
    assign w_ctrl_wr   = w_wr_en && (reg_address == A_CTRL) && (write_data[1:0] != 2'b00);
    assign w_accept    = w_ctrl_wr && !w_busy && (w_len_eff != '0);
    assign w_bidx      = NB_W'(reg_bytecnt);
    assign w_bidx_ok   = (32'(reg_bytecnt) < NB);
    assign w_din_wr    = w_wr_en && (reg_address == A_DIN) && w_bidx_ok && !w_busy;
    assign w_res_store = w_busy && I_out_valid && (r_wr_ptr != PTR_FULL);
    assign w_cyc_ext   = CBW'(r_cycles);

    // Bank byte address of a word is word*BPW+byte, matching the host's little-endian byte index.
    always_comb begin
        w_word = '0;
        for (int unsigned b = 0; b < BPW; b++)
            w_word[b*8 +: 8] = r_din[NB_W'(32'(r_rd_ptr[IDX_W-1:0]) * BPW + b)];
    end

    assign O_word       = w_stream ? w_word : '0;
    assign O_word_valid = w_stream;
    assign O_word_last  = w_last;
    assign O_out_ready  = w_busy;
    assign O_busy       = w_busy;
    assign O_start      = r_start;
    assign O_init       = r_init;
    assign read_data    = r_read;

    always_ff @(posedge crypto_clk) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_len    <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_cycles <= '0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
            r_ign    <= 1'b0;
            r_done_q <= 1'b0;
            r_start  <= 1'b0;
            r_init   <= 1'b0;
        end else begin
            r_done_q <= I_done;
            r_start  <= 1'b0;
            r_init   <= 1'b0;

            if (w_wr_en && (reg_address == A_LEN) && (reg_bytecnt == '0) && !w_busy)
                r_len <= write_data;

            if (w_ctrl_wr) begin
                if (w_accept) begin
                    r_start  <= ~write_data[1];
                    r_init   <= write_data[1];
                    r_state  <= S_STREAM;
                    r_rd_ptr <= '0;
                    r_wr_ptr <= '0;
                    r_cycles <= '0;
                    r_done   <= 1'b0;
                    r_ovf    <= 1'b0;
                    r_unf    <= 1'b0;
                    r_ign    <= 1'b0;
                end else begin
                    r_ign <= 1'b1;
                end
            end

            // A done edge in the same cycle as the last handshake counts as a clean finish.
            case (r_state)
                S_STREAM: begin
                    if (w_hs)
                        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                    if (w_done_rise) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                        if (!(w_hs && w_last))
                            r_unf <= 1'b1;
                    end else if (w_hs && w_last) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_done_rise) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: ;
            endcase

            if (w_busy) begin
                if (r_cycles != '1)
                    r_cycles <= r_cycles + pCNT_WIDTH'(1);
                if (I_out_valid) begin
                    if (r_wr_ptr == PTR_FULL)
                        r_ovf <= 1'b1;
                    else
                        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge crypto_clk) begin
        if (w_din_wr)
            r_din[w_bidx] <= write_data;
        if (w_res_store)
            for (int unsigned b = 0; b < BPW; b++)
                r_dout[NB_W'(32'(r_wr_ptr[IDX_W-1:0]) * BPW + b)] <= I_out_word[b*8 +: 8];
    end

    always_comb begin
        w_rd_byte = '0;
        case (reg_address)
            A_STATUS: w_rd_byte = {3'b000, r_ign, r_unf, r_ovf, r_done, w_busy};
            A_LEN:    if (reg_bytecnt == '0) w_rd_byte = r_len;
            A_OUTCNT: if (reg_bytecnt == '0) w_rd_byte = 8'(r_wr_ptr);
            A_CYCLES: begin
                for (int unsigned b = 0; b < CBW / 8; b++)
                    if (32'(reg_bytecnt) == b)
                        w_rd_byte = w_cyc_ext[b*8 +: 8];
            end
            A_DIN:    if (w_bidx_ok) w_rd_byte = r_din[w_bidx];
            A_DOUT:   if (w_bidx_ok) w_rd_byte = r_dout[w_bidx];
            default:  ;
        endcase
    end

    always_ff @(posedge crypto_clk) begin
        if (!reset_n)
            r_read <= '0;
        else if (w_rd_en)
            r_read <= w_rd_byte;
        else
            r_read <= '0;
    end

endmodule
